// File: rtl/uart_rx_frame_buffer_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_buffer_if
// Groups the byte-input and read/status signals of uart_rx_frame_buffer.
// Signal names carry the frame buffer's own direction (i_ = into the block).
//   i_rx_dv, i_rx_byte : byte strobe and byte from the UART receiver
//   i_rd, i_clr_err    : pop head byte / clear sticky overflow (PIO side)
//   o_data, o_empty    : first-word-fall-through head byte and empty flag
//   o_count            : committed bytes available
//   o_frame_ok/err     : one-cycle frame commit / discard pulses
//   o_overflow         : sticky frame-lost-to-full flag
// Modports: slave = frame buffer, master = receiver/poller side.
// ---------------------------------------------------------------------------
interface uart_rx_frame_buffer_if #(
  parameter int unsigned DEPTH = 16
) ();
  logic                     i_rx_dv;
  logic [7:0]               i_rx_byte;
  logic                     i_rd;
  logic                     i_clr_err;
  logic [7:0]               o_data;
  logic                     o_empty;
  logic [$clog2(DEPTH):0]   o_count;
  logic                     o_frame_ok;
  logic                     o_frame_err;
  logic                     o_overflow;

  modport slave (
    input  i_rx_dv, i_rx_byte, i_rd, i_clr_err,
    output o_data, o_empty, o_count, o_frame_ok, o_frame_err, o_overflow
  );

  modport master (
    output i_rx_dv, i_rx_byte, i_rd, i_clr_err,
    input  o_data, o_empty, o_count, o_frame_ok, o_frame_err, o_overflow
  );
endinterface

// File: rtl/uart_rx_frame_buffer.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_buffer
// Hunts for SYNC_BYTE in the UART byte stream, parses a length-prefixed,
// checksummed frame and writes its payload into a FIFO. Payload becomes
// readable only once the checksum passes (speculative write pointer that is
// either committed or rolled back).
// Ports:
//   clk_clk     : system clock
//   reset_reset : asynchronous active-low reset
//   bus         : uart_rx_frame_buffer_if.slave (byte input, read/status)
// ---------------------------------------------------------------------------
module uart_rx_frame_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input logic                   clk_clk,
  input logic                   reset_reset,
  uart_rx_frame_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StLen, StPayload, StCheck} state_e;

  state_e        r_state;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_commit;
  logic [PW-1:0] r_wr_spec;
  logic [PW-1:0] r_len;        // payload bytes still to come
  logic [7:0]    r_sum;
  logic [TW-1:0] r_tmo;
  logic          r_frame_ok;
  logic          r_frame_err;
  logic          r_overflow;
  logic [7:0]    r_mem [DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_rd;
  logic          w_wr;
  logic          w_timeout;
  logic          w_len_bad;
  logic [PW-1:0] w_fill;
  logic [TW-1:0] w_tmo_next;
  logic [7:0]    w_sum_next;

  assign w_empty    = (r_wr_commit == r_rd_ptr);
  // Fill counts speculative bytes too, so a pending frame cannot overrun
  // committed data that has not been read yet.
  assign w_fill     = r_wr_spec - r_rd_ptr;
  assign w_full     = (w_fill == PW'(DEPTH));
  assign w_rd       = bus.i_rd & ~w_empty;
  assign w_wr       = (r_state == StPayload) & bus.i_rx_dv & ~w_full;
  assign w_sum_next = r_sum + bus.i_rx_byte;
  assign w_len_bad  = (bus.i_rx_byte == 8'h00) || (32'(bus.i_rx_byte) > MAX_LEN);
  assign w_tmo_next = r_tmo + 1'b1;
  // Fires on the idle cycle that would take the counter to TIMEOUT_CYC, so
  // the error pulse lands TIMEOUT_CYC+1 cycles after the last byte.
  assign w_timeout  = (r_state != StIdle) & ~bus.i_rx_dv & (w_tmo_next == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk_clk or negedge reset_reset) begin
    if (!reset_reset) begin
      r_state     <= StIdle;
      r_rd_ptr    <= '0;
      r_wr_commit <= '0;
      r_wr_spec   <= '0;
      r_len       <= '0;
      r_sum       <= '0;
      r_tmo       <= '0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;

      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;

      // Cleared first so an overflow set later in this block wins.
      if (bus.i_clr_err) r_overflow <= 1'b0;

      if (r_state == StIdle || bus.i_rx_dv) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= w_tmo_next;
      end

      if (w_timeout) begin
        r_wr_spec   <= r_wr_commit;
        r_frame_err <= 1'b1;
        r_tmo       <= '0;
        r_state     <= StIdle;
      end else if (bus.i_rx_dv) begin
        unique case (r_state)
          StIdle: begin
            if (bus.i_rx_byte == SYNC_BYTE) r_state <= StLen;
          end
          StLen: begin
            if (w_len_bad) begin
              r_wr_spec   <= r_wr_commit;
              r_frame_err <= 1'b1;
              r_state     <= StIdle;
            end else begin
              r_len   <= PW'(bus.i_rx_byte);
              r_sum   <= bus.i_rx_byte;
              r_state <= StPayload;
            end
          end
          StPayload: begin
            if (w_full) begin
              r_wr_spec   <= r_wr_commit;
              r_overflow  <= 1'b1;
              r_frame_err <= 1'b1;
              r_state     <= StIdle;
            end else begin
              r_wr_spec <= r_wr_spec + 1'b1;
              r_sum     <= w_sum_next;
              r_len     <= r_len - 1'b1;
              if (r_len == PW'(1)) r_state <= StCheck;
            end
          end
          StCheck: begin
            if (w_sum_next == 8'h00) begin
              r_wr_commit <= r_wr_spec;
              r_frame_ok  <= 1'b1;
            end else begin
              r_wr_spec   <= r_wr_commit;
              r_frame_err <= 1'b1;
            end
            r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_clk) begin
    if (w_wr) r_mem[r_wr_spec[AW-1:0]] <= bus.i_rx_byte;
  end

  assign bus.o_data      = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign bus.o_empty     = w_empty;
  assign bus.o_count     = r_wr_commit - r_rd_ptr;
  assign bus.o_frame_ok  = r_frame_ok;
  assign bus.o_frame_err = r_frame_err;
  assign bus.o_overflow  = r_overflow;
endmodule

// File: tb/tb_uart_rx_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame_buffer
// Directed frames drive the byte input; expected frame events and expected
// read bytes are queued when stimulus is issued, and a monitor on the
// falling edge pops and compares whenever the DUT pulses a frame event or a
// read is accepted.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame_buffer;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TMO     = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_frame_buffer_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_frame_buffer #(
    .DEPTH       (DEPTH),
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst_n),
    .bus         (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_data[$];
  bit         exp_evt[$];   // 1 = frame_ok, 0 = frame_err

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_frame_ok || bus.o_frame_err) begin
        checks++;
        if (bus.o_frame_ok && bus.o_frame_err) begin
          errors++;
          $display("FAIL evt_both: got ok=1 err=1 expected one of them");
        end else if (exp_evt.size() == 0) begin
          errors++;
          $display("FAIL evt_unexpected: got ok=%0b err=%0b expected none",
                   bus.o_frame_ok, bus.o_frame_err);
        end else begin
          bit e;
          e = exp_evt.pop_front();
          if (bus.o_frame_ok !== e) begin
            errors++;
            $display("FAIL evt_kind: got ok=%0b expected ok=%0b", bus.o_frame_ok, e);
          end
        end
      end
      if (bus.i_rd && !bus.o_empty) begin
        checks++;
        if (exp_data.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got %0h expected no data", bus.o_data);
        end else begin
          logic [7:0] d;
          d = exp_data.pop_front();
          if (bus.o_data !== d) begin
            errors++;
            $display("FAIL rd_data: got %0h expected %0h", bus.o_data, d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    bus.i_rx_dv   = 1'b1;
    bus.i_rx_byte = b;
    tick();
    bus.i_rx_dv   = 1'b0;
  endtask

  task automatic send(input logic [7:0] fr[$]);
    foreach (fr[i]) put(fr[i]);
  endtask

  task automatic pop(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_rd = 1'b1;
      tick();
      bus.i_rd = 1'b0;
    end
  endtask

  task automatic expect_bytes(input logic [7:0] b[$]);
    foreach (b[i]) exp_data.push_back(b[i]);
  endtask

  task automatic check_reset_outputs();
    check("rst_empty", 32'(bus.o_empty), 1);
    check("rst_count", 32'(bus.o_count), 0);
    check("rst_data", 32'(bus.o_data), 0);
    check("rst_ok", 32'(bus.o_frame_ok), 0);
    check("rst_err", 32'(bus.o_frame_err), 0);
    check("rst_ovf", 32'(bus.o_overflow), 0);
  endtask

  initial begin
    int k;
    bus.i_rx_dv   = 1'b0;
    bus.i_rx_byte = 8'h00;
    bus.i_rd      = 1'b0;
    bus.i_clr_err = 1'b0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Valid frame, then drain.
    exp_evt.push_back(1'b1);
    expect_bytes('{8'h11, 8'h22, 8'h33});
    send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97});
    check("f1_count", 32'(bus.o_count), 3);
    check("f1_empty", 32'(bus.o_empty), 0);
    pop(3);
    check("f1_drained", 32'(bus.o_empty), 1);
    check("f1_count0", 32'(bus.o_count), 0);

    // Bad checksum, then a good frame.
    exp_evt.push_back(1'b0);
    send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98});
    check("bad_count", 32'(bus.o_count), 0);
    exp_evt.push_back(1'b1);
    expect_bytes('{8'h40, 8'h41});
    send('{8'hA5, 8'h02, 8'h40, 8'h41, 8'h7D});
    check("f3_count", 32'(bus.o_count), 2);
    pop(2);
    check("f3_count0", 32'(bus.o_count), 0);

    // Illegal lengths 0 and 17.
    exp_evt.push_back(1'b0);
    exp_evt.push_back(1'b0);
    send('{8'hA5, 8'h00, 8'hA5, 8'h11});
    check("len_count", 32'(bus.o_count), 0);
    exp_evt.push_back(1'b1);
    expect_bytes('{8'h55});
    send('{8'hA5, 8'h01, 8'h55, 8'hAA});
    check("len_next_count", 32'(bus.o_count), 1);
    pop(1);

    // Overflow: two 10-byte frames, no reads.
    exp_evt.push_back(1'b1);
    expect_bytes('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A});
    send('{8'hA5, 8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
           8'h0A, 8'hBF});
    check("ovf_first_count", 32'(bus.o_count), 10);
    exp_evt.push_back(1'b0);
    send('{8'hA5, 8'h0A, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27});
    check("ovf_flag", 32'(bus.o_overflow), 1);
    send('{8'h28, 8'h29, 8'h2A, 8'h7F});
    check("ovf_count", 32'(bus.o_count), 10);
    bus.i_clr_err = 1'b1;
    tick();
    bus.i_clr_err = 1'b0;
    check("ovf_cleared", 32'(bus.o_overflow), 0);
    pop(10);
    check("ovf_drained", 32'(bus.o_empty), 1);

    // Timeout mid-payload.
    exp_evt.push_back(1'b0);
    send('{8'hA5, 8'h02, 8'h11});
    k = 0;
    for (int i = 1; i <= int'(TMO) + 10; i++) begin
      @(negedge clk);
      k = i;
      if (bus.o_frame_err) break;
    end
    check("tmo_latency", 32'(k), TMO + 1);
    tick();
    check("tmo_count", 32'(bus.o_count), 0);
    exp_evt.push_back(1'b1);
    expect_bytes('{8'h40, 8'h41});
    send('{8'hA5, 8'h02, 8'h40, 8'h41, 8'h7D});
    check("tmo_next_count", 32'(bus.o_count), 2);

    // Reset mid-payload discards everything, committed data included.
    send('{8'hA5, 8'h03, 8'h11});
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_data.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_count", 32'(bus.o_count), 0);

    // Read while empty is ignored.
    pop(1);
    check("rd_empty_count", 32'(bus.o_count), 0);
    check("rd_empty_flag", 32'(bus.o_empty), 1);

    // Commit and read in the same cycle: 3 + 2 - 1.
    exp_evt.push_back(1'b1);
    expect_bytes('{8'h11, 8'h22, 8'h33});
    send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97});
    check("cr_pre_count", 32'(bus.o_count), 3);
    exp_evt.push_back(1'b1);
    expect_bytes('{8'h40, 8'h41});
    send('{8'hA5, 8'h02, 8'h40, 8'h41});
    bus.i_rd = 1'b1;
    put(8'h7D);
    bus.i_rd = 1'b0;
    check("cr_count", 32'(bus.o_count), 4);
    pop(4);
    check("cr_drained", 32'(bus.o_empty), 1);

    tick();
    tick();
    check("evt_left", 32'(exp_evt.size()), 0);
    check("data_left", 32'(exp_data.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
